// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle EX-stage ALU with valid/ready handshakes
//
// Purpose: executes one ALU operation per accepted request and holds the
// registered result and zero flag until the downstream stage consumes it.
// Shifts are bit-serial (one bit per cycle) unless ALU_FAST_SHIFT_EN is
// defined, in which case a barrel shifter gives every op 1-cycle latency.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready request handshake carrying Operation, SrcA, SrcB
//   Operation         4-bit ALU controller code
//   SrcA, SrcB        operands; shift amount is SrcB[4:0]
//   out_valid/out_ready result handshake
//   ALUResult, Zero   registered result and (ALUResult == 0)
//
// Build option: ALU_FAST_SHIFT_EN

module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_GE  = 4'b1001;
    localparam logic [3:0] OP_NE  = 4'b1010;
    localparam logic [3:0] OP_LT  = 4'b1100;
    localparam logic [3:0] OP_JAL = 4'b1101;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [4:0]        cnt;
    shift_t            kind;
`endif

    state_t            state;
    logic [4:0]        shamt;
    logic              is_shift;
    logic              lt_signed;
    logic [DATA_W-1:0] alu_value;

    assign shamt     = SrcB[4:0];
    assign is_shift  = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
    assign lt_signed = $signed(SrcA) < $signed(SrcB);
    assign in_ready  = (state == IDLE) && !reset;

    // Single-cycle result for everything the IDLE state can finish directly.
    always_comb begin
        alu_value = '0;
        case (Operation)
            OP_AND: alu_value = SrcA & SrcB;
            OP_OR:  alu_value = SrcA | SrcB;
            OP_ADD: alu_value = SrcA + SrcB;
            OP_XOR: alu_value = SrcA ^ SrcB;
            OP_SUB: alu_value = SrcA - SrcB;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL: alu_value = SrcA << shamt;
            OP_SRL: alu_value = SrcA >> shamt;
            OP_SRA: alu_value = DATA_W'($signed(SrcA) >>> shamt);
`else
            // Only reached with a zero shift amount; longer shifts go serial.
            OP_SLL, OP_SRL, OP_SRA: alu_value = SrcA;
`endif
            OP_EQ:  alu_value[0] = (SrcA == SrcB);
            OP_NE:  alu_value[0] = (SrcA != SrcB);
            OP_LT:  alu_value[0] = lt_signed;
            OP_GE:  alu_value[0] = !lt_signed;
            OP_JAL: alu_value[0] = 1'b1;
            default: alu_value = '0;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    always_comb begin
        acc_next = acc;
        case (kind)
            SH_LL:   acc_next = {acc[DATA_W-2:0], 1'b0};
            SH_RL:   acc_next = {1'b0, acc[DATA_W-1:1]};
            SH_RA:   acc_next = {acc[DATA_W-1], acc[DATA_W-1:1]};
            default: acc_next = acc;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
            acc       <= '0;
            cnt       <= '0;
            kind      <= SH_LL;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
                        if (is_shift && (shamt != 5'd0)) begin
                            acc   <= SrcA;
                            cnt   <= shamt;
                            kind  <= (Operation == OP_SLL) ? SH_LL :
                                     (Operation == OP_SRL) ? SH_RL : SH_RA;
                            state <= SHIFT;
                        end else
`endif
                        begin
                            ALUResult <= alu_value;
                            Zero      <= (alu_value == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - 5'd1;
                    // Last bit position: publish the shifted value directly.
                    if (cnt == 5'd1) begin
                        ALUResult <= acc_next;
                        Zero      <= (acc_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Keeps the combinational decode of shift ops referenced in the fast build.
    logic unused_is_shift;
    assign unused_is_shift = is_shift;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (operation),
        .SrcA      (src_a),
        .SrcB      (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (alu_result),
        .Zero      (zero)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: arithmetic definitions of each operation.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        longint      sa;
        longint      pw;
        longint      q;
        logic [63:0] p;
        n  = int'(b % 32);
        sa = longint'($signed(a));
        pw = longint'(1) << n;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd6:  return a - b;
            4'd4: begin
                p = {32'd0, a} * 64'(pw);
                return p[31:0];
            end
            4'd5:  return a / 32'(pw);
            4'd7: begin
                q = (sa >= 0) ? (sa / pw) : ((sa - (pw - 1)) / pw);
                return q[31:0];
            end
            4'd8:  return (a == b) ? 32'd1 : 32'd0;
            4'd10: return (a != b) ? 32'd1 : 32'd0;
            4'd12: return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd9:  return (sa >= longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd13: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && (b % 32) != 0)
            return int'(b % 32) + 1;
        return 1;
`endif
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] exp_res;
        logic [31:0] held;
        int          exp_lat;
        int          lat;
        int          waits;
        logic        leak;
        exp_res = ref_alu(op, a, b);
        exp_lat = ref_latency(op, b);
        waits   = 0;
        @(negedge clk);
        while (!in_ready && waits < 64) begin
            @(negedge clk);
            waits++;
        end
        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        operation = op;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 4'($urandom);
        src_a     = $urandom;
        src_b     = $urandom;
        lat  = 0;
        leak = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) leak = 1'b1;
        end while (!out_valid && lat < 64);
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("busy_in_ready", 32'(leak), 32'd0);
        check_val("result", alu_result, exp_res);
        check_val("zero", 32'(zero), (exp_res == 32'd0) ? 32'd1 : 32'd0);
        held = alu_result;
        leak = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            if (alu_result !== held || !out_valid || in_ready) leak = 1'b1;
        end
        if (stall > 0) check_val("backpressure_hold", 32'(leak), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("drained_valid", 32'(out_valid), 32'd0);
        check_val("drained_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = 4'd0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_result", alu_result, 32'd0);
        check_val("rst_zero", 32'(zero), 32'd1);
        reset = 1'b0;

        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b0110, 32'h8000_0000, 32'd1, 0);
        run_op(4'b1100, 32'h8000_0000, 32'd1, 0);
        run_op(4'b1001, 32'h8000_0000, 32'd1, 0);
        run_op(4'b1000, 32'd5, 32'd5, 0);
        run_op(4'b1010, 32'd5, 32'd5, 0);
        run_op(4'b0111, 32'h8000_0000, 32'h23, 0);
        run_op(4'b0100, 32'h1234, 32'h0, 0);
        run_op(4'b1111, 32'hDEAD_BEEF, 32'h1234, 0);
        run_op(4'b0001, 32'hA0, 32'h05, 5);
        run_op(4'b0100, 32'h0000_0001, 32'd31, 1);
        run_op(4'b0101, 32'h8000_0000, 32'd31, 0);
        run_op(4'b1101, 32'd0, 32'd0, 0);

        // Abort a serial shift with reset during its second cycle.
        @(negedge clk);
        operation = 4'b0101;
        src_a     = 32'hF0F0_0000;
        src_b     = 32'd10;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_result", alu_result, 32'd0);
        check_val("abort_zero", 32'(zero), 32'd1);
        check_val("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_reset_ready", 32'(in_ready), 32'd1);
        check_val("post_reset_valid", 32'(out_valid), 32'd0);
        run_op(4'b0010, 32'd2, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000 | 32'($urandom_range(0, 7));
            run_op(op, a, b, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
